// File: rtl/ram_burst_master.sv
//==============================================================================
// Module      : ram_burst_master
// Description : Burst initiator for one port of a 64x8 dual-port RAM.
//               Takes read/write burst commands over valid/ready, streams write
//               beats into consecutive RAM locations or returns consecutive
//               locations on a read stream through a 2-entry output FIFO.
//               Optional macro RAM_BURST_BOUNDARY_CHK_EN rejects bursts that
//               would cross the top of the address space (err pulse).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_burst_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam int                c_CNT_W    = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [c_CNT_W-1:0] r_remain;      // beats still to transfer (write) or issue (read)
    logic [c_CNT_W-1:0] w_remain_next;
    logic               w_done_set;
    logic               r_done;
    logic               w_issue;
    logic               w_pop;
    logic               w_boundary_bad;

    // Read pipeline: one registered in-flight flag plus a 2-entry FIFO
    logic               r_inflight;
    logic               r_inflight_last;
    logic [DATA_W-1:0]  r_fifo_data [0:1];
    logic               r_fifo_last [0:1];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;

`ifdef RAM_BURST_BOUNDARY_CHK_EN
    assign w_boundary_bad = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > {1'b0, {ADDR_W{1'b1}}};
`else
    assign w_boundary_bad = 1'b0;
`endif

    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = rd_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign rd_last  = rd_valid & r_fifo_last[r_rd_ptr];
    assign w_pop    = rd_valid & rd_ready;
    assign done     = r_done;

    // Next-state, address/count bookkeeping and RAM-side outputs
    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_remain_next = r_remain;
        w_done_set    = 1'b0;
        w_issue       = 1'b0;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_data      = '0;
        case (r_state)
            c_ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst && !w_boundary_bad) begin
                    w_addr_next   = cmd_addr;
                    w_remain_next = {1'b0, cmd_len} + c_CNT_ONE;
                    w_state_next  = cmd_write ? c_ST_WRITE : c_ST_READ;
                end
            end
            c_ST_WRITE: begin
                // RAM write happens on the same edge as the wr handshake
                wr_ready = ~rst;
                ram_we   = wr_valid & ~rst;
                ram_addr = r_addr;
                ram_data = wr_data;
                if (wr_valid) begin
                    w_addr_next   = r_addr + c_ADDR_ONE;
                    w_remain_next = r_remain - c_CNT_ONE;
                    if (r_remain == c_CNT_ONE) begin
                        w_state_next = c_ST_IDLE;
                        w_done_set   = 1'b1;
                    end
                end
            end
            c_ST_READ: begin
                ram_addr = r_addr;
                // Only issue when the result is guaranteed a FIFO slot
                if (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop})) begin
                    w_issue       = 1'b1;
                    w_addr_next   = r_addr + c_ADDR_ONE;
                    w_remain_next = r_remain - c_CNT_ONE;
                    if (r_remain == c_CNT_ONE) begin
                        w_state_next = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && rd_last) begin
                    w_state_next = c_ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_remain <= w_remain_next;
            r_done   <= w_done_set;
        end
    end

    // Read pipeline control: in-flight flag, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == c_CNT_ONE);
            if (r_inflight) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // FIFO storage captures ram_q one cycle after the read was issued
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifo_data[r_wr_ptr] <= ram_q;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
        end
    end

`ifdef RAM_BURST_BOUNDARY_CHK_EN
    logic r_err;

    // Rejected command: accepted on the handshake, flagged one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= cmd_valid & cmd_ready & w_boundary_bad;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire
